// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the multi-lane parallel-to-serial converter.
package p2s_pkg;

   typedef enum logic {
      SR_EMPTY = 1'b0,
      SR_SHIFT = 1'b1
   } sr_state_t;

   function automatic int beats_f(input int data_w, input int out_w);
      return data_w / out_w;
   endfunction

   // A single-beat word still needs a one-bit counter so port widths never collapse to zero.
   function automatic int cnt_w_f(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/p2s_beat_mux.sv
// Combinational beat selector: picks beat number cnt_i of a word in LSB- or MSB-first order.
module p2s_beat_mux
   import p2s_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 2,
   localparam int BEATS = beats_f(DATA_W, OUT_W),
   localparam int CNT_W = cnt_w_f(BEATS)
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              msb_first_i,
   output logic [OUT_W-1:0]  beat_o
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   logic [OUT_W-1:0] chunk [BEATS];
   logic [CNT_W-1:0] idx;

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_chunk
         assign chunk[gi] = word_i[gi*OUT_W +: OUT_W];
      end
   endgenerate

   // MSB-first beat k is simply chunk BEATS-1-k of the LSB-first slicing.
   always_comb begin
      idx = cnt_i;
      if (msb_first_i) begin
         idx = LAST_IDX - cnt_i;
      end
      beat_o = chunk[idx];
   end

endmodule

// File: rtl/parallel_to_serial_mlane.sv
// Double-buffered word-to-beat serializer on valid/ready streams.
// Optional s_last_o output is enabled by defining P2S_LAST_EN.
module parallel_to_serial_mlane
   import p2s_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              msb_first_i,
   input  logic              p_valid_i,
   input  logic [DATA_W-1:0] p_data_i,
   output logic              p_ready_o,
   output logic              s_valid_o,
   output logic [OUT_W-1:0]  s_data_o,
   input  logic              s_ready_i,
   output logic              busy_o
`ifdef P2S_LAST_EN
   ,
   output logic              s_last_o
`endif
);

   localparam int BEATS = beats_f(DATA_W, OUT_W);
   localparam int CNT_W = cnt_w_f(BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   generate
      if (OUT_W < 1) begin : g_bad_out_w
         $error("parallel_to_serial_mlane: OUT_W must be >= 1");
      end else if ((DATA_W % OUT_W) != 0) begin : g_bad_ratio
         $error("parallel_to_serial_mlane: DATA_W must be a multiple of OUT_W");
      end
   endgenerate

   sr_state_t         state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic              sr_msb_q, sr_msb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hb_q, hb_d;
   logic              hb_msb_q, hb_msb_d;
   logic              hb_valid_q, hb_valid_d;

   logic              s_valid;
   logic              xfer;
   logic              drain;
   logic              accept;
   logic [OUT_W-1:0]  beat;

   assign s_valid   = (state_q == SR_SHIFT);
   assign xfer      = s_valid && s_ready_i;
   assign drain     = xfer && (cnt_q == LAST_CNT);
   assign p_ready_o = !hb_valid_q && reset_n;
   assign accept    = p_valid_i && p_ready_o;

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      sr_msb_d   = sr_msb_q;
      cnt_d      = cnt_q;
      hb_d       = hb_q;
      hb_msb_d   = hb_msb_q;
      hb_valid_d = hb_valid_q;

      if (xfer && !drain) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // The holding buffer always has priority on reload; while it is full p_ready is low anyway.
      if (drain) begin
         cnt_d = '0;
         if (hb_valid_q) begin
            sr_d       = hb_q;
            sr_msb_d   = hb_msb_q;
            hb_valid_d = 1'b0;
         end else if (accept) begin
            sr_d     = p_data_i;
            sr_msb_d = msb_first_i;
         end else begin
            state_d = SR_EMPTY;
         end
      end else if (accept) begin
         if (state_q == SR_EMPTY) begin
            state_d  = SR_SHIFT;
            sr_d     = p_data_i;
            sr_msb_d = msb_first_i;
            cnt_d    = '0;
         end else begin
            hb_d       = p_data_i;
            hb_msb_d   = msb_first_i;
            hb_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= SR_EMPTY;
         sr_q       <= '0;
         sr_msb_q   <= 1'b0;
         cnt_q      <= '0;
         hb_q       <= '0;
         hb_msb_q   <= 1'b0;
         hb_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         sr_msb_q   <= sr_msb_d;
         cnt_q      <= cnt_d;
         hb_q       <= hb_d;
         hb_msb_q   <= hb_msb_d;
         hb_valid_q <= hb_valid_d;
      end
   end

   p2s_beat_mux #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
   ) u_beat_mux (
      .word_i      (sr_q),
      .cnt_i       (cnt_q),
      .msb_first_i (sr_msb_q),
      .beat_o      (beat)
   );

   assign s_valid_o = s_valid;
   assign s_data_o  = s_valid ? beat : '0;
   assign busy_o    = s_valid || hb_valid_q;

`ifdef P2S_LAST_EN
   assign s_last_o = s_valid && (cnt_q == LAST_CNT);
`endif

endmodule

// File: tb/tb_parallel_to_serial_mlane.sv
// Directed bench for parallel_to_serial_mlane: 8/2 lane instance plus an 8/8 pass-through instance.
module tb_parallel_to_serial_mlane;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       msb, pv, pr, sv, sr_i, busy;
   logic [7:0] pd;
   logic [1:0] sd;
   logic       msb8, pv8, pr8, sv8, sr8, busy8;
   logic [7:0] pd8, sd8;
`ifdef P2S_LAST_EN
   logic       slast, slast8;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   parallel_to_serial_mlane #(.DATA_W(8), .OUT_W(2)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .msb_first_i (msb),
      .p_valid_i   (pv),
      .p_data_i    (pd),
      .p_ready_o   (pr),
      .s_valid_o   (sv),
      .s_data_o    (sd),
      .s_ready_i   (sr_i),
      .busy_o      (busy)
`ifdef P2S_LAST_EN
      ,
      .s_last_o    (slast)
`endif
   );

   parallel_to_serial_mlane #(.DATA_W(8), .OUT_W(8)) u_dut8 (
      .clk         (clk),
      .reset_n     (reset_n),
      .msb_first_i (msb8),
      .p_valid_i   (pv8),
      .p_data_i    (pd8),
      .p_ready_o   (pr8),
      .s_valid_o   (sv8),
      .s_data_o    (sd8),
      .s_ready_i   (sr8),
      .busy_o      (busy8)
`ifdef P2S_LAST_EN
      ,
      .s_last_o    (slast8)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_chk(input string tag, input int k, input int exp_d);
      check($sformatf("%s_valid%0d", tag, k), 32'(sv), 32'd1);
      check($sformatf("%s_data%0d", tag, k), 32'(sd), 32'(exp_d));
`ifdef P2S_LAST_EN
      check($sformatf("%s_last%0d", tag, k), 32'(slast), 32'((k % 4) == 3));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e1 [4] = '{0, 1, 3, 2};
      int e2 [4] = '{2, 3, 1, 0};
      int e3 [8] = '{0, 1, 3, 2, 2, 2, 1, 1};
      int r3 [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
      int e4 [6] = '{0, 1, 1, 1, 3, 2};
      int rd4[6] = '{1, 0, 0, 1, 1, 1};
      int e5 [4] = '{2, 2, 1, 1};
      logic [7:0] w8 [3] = '{8'h11, 8'h22, 8'h33};

      reset_n = 1'b0; msb = 1'b0; pv = 1'b0; pd = 8'h00; sr_i = 1'b1;
      msb8 = 1'b0; pv8 = 1'b0; pd8 = 8'h00; sr8 = 1'b1;
      step(); step();

      // reset state
      check("rst_p_ready", 32'(pr), 32'd0);
      check("rst_s_valid", 32'(sv), 32'd0);
      check("rst_s_data", 32'(sd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p_ready8", 32'(pr8), 32'd0);
`ifdef P2S_LAST_EN
      check("rst_last", 32'(slast), 32'd0);
`endif
      reset_n = 1'b1;
      #1;
      check("rel_p_ready", 32'(pr), 32'd1);
      $display("reset: released");

      // 1: LSB-first 0xB4
      pv = 1'b1; pd = 8'hB4; msb = 1'b0;
      step();
      pv = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat_chk("t1", k, e1[k]);
         check($sformatf("t1_busy%0d", k), 32'(busy), 32'd1);
         step();
      end
      check("t1_idle_valid", 32'(sv), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_data", 32'(sd), 32'd0);
      $display("t1: word 0xb4 lsb-first sent");

      // 2: MSB-first 0xB4
      pv = 1'b1; pd = 8'hB4; msb = 1'b1;
      step();
      pv = 1'b0; msb = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat_chk("t2", k, e2[k]);
         step();
      end
      check("t2_idle_valid", 32'(sv), 32'd0);
      $display("t2: word 0xb4 msb-first sent");

      // 3: back-to-back 0xB4, 0x5A, no bubble
      pv = 1'b1; pd = 8'hB4; msb = 1'b0;
      step();
      for (int k = 0; k < 8; k++) begin
         beat_chk("t3", k, e3[k]);
         check($sformatf("t3_p_ready%0d", k), 32'(pr), 32'(r3[k]));
         if (k == 0) pd = 8'h5A;
         if (k == 1) pv = 1'b0;
         step();
      end
      check("t3_idle_valid", 32'(sv), 32'd0);
      $display("t3: words 0xb4,0x5a sent back-to-back");

      // 4: stall mid-word
      pv = 1'b1; pd = 8'hB4; msb = 1'b0;
      step();
      pv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t4_valid%0d", k), 32'(sv), 32'd1);
         check($sformatf("t4_data%0d", k), 32'(sd), 32'(e4[k]));
         sr_i = rd4[k][0];
         step();
      end
      sr_i = 1'b1;
      check("t4_idle_valid", 32'(sv), 32'd0);
      $display("t4: word 0xb4 sent with 2-cycle stall");

      // 5: reset with HB full
      pv = 1'b1; pd = 8'hB4; msb = 1'b0;
      step();
      pd = 8'h5A;
      step();
      check("t5_pre_data", 32'(sd), 32'd1);
      check("t5_pre_p_ready", 32'(pr), 32'd0);
      check("t5_pre_busy", 32'(busy), 32'd1);
      reset_n = 1'b0; pv = 1'b0;
      step();
      check("t5_rst_valid", 32'(sv), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_p_ready", 32'(pr), 32'd0);
      check("t5_rst_data", 32'(sd), 32'd0);
      reset_n = 1'b1;
      #1;
      check("t5_rel_p_ready", 32'(pr), 32'd1);
      check("t5_rel_valid", 32'(sv), 32'd0);
      pv = 1'b1; pd = 8'h5A;
      step();
      pv = 1'b0;
      for (int k = 0; k < 4; k++) begin
         beat_chk("t5", k, e5[k]);
         step();
      end
      check("t5_idle_valid", 32'(sv), 32'd0);
      $display("t5: reset mid-word, then word 0x5a sent");

      // 6: pass-through width
      pv8 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pd8 = w8[k];
         check($sformatf("t6_p_ready%0d", k), 32'(pr8), 32'd1);
         step();
         check($sformatf("t6_valid%0d", k), 32'(sv8), 32'd1);
         check($sformatf("t6_data%0d", k), 32'(sd8), 32'(w8[k]));
`ifdef P2S_LAST_EN
         check($sformatf("t6_last%0d", k), 32'(slast8), 32'd1);
`endif
      end
      pv8 = 1'b0;
      check("t6_p_ready_end", 32'(pr8), 32'd1);
      step();
      check("t6_idle_valid", 32'(sv8), 32'd0);
      check("t6_idle_busy", 32'(busy8), 32'd0);
      $display("t6: words 0x11,0x22,0x33 passed through");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
